// File: rtl/pipe_stage_buf_pkg.sv
// Shared sizing helpers and stage payload layouts for pipe_stage_buf instances.
// Stages instantiate the buffer with DATA_W = $bits(<stage struct>).
package pipe_stage_buf_pkg;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int pipe_buf_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int pipe_buf_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifToId_t;

  localparam int IF_TO_ID_W = $bits(ifToId_t);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [7:0]  alu_op;
    logic        wb_en;
  } idToEx_t;

  localparam int ID_TO_EX_W = $bits(idToEx_t);

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic DEPTH-entry in-order pipeline-stage buffer with synchronous flush.
// Define PIPE_BUF_PERF_EN to add the saturating downstream-stall counter port stall_cnt_o.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 2,
  parameter int READY_PASS = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [DATA_W-1:0]                  in_data_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [DATA_W-1:0]                  out_data_o,
  output logic [pipe_buf_cnt_w(DEPTH)-1:0]   count_o
`ifdef PIPE_BUF_PERF_EN
  ,
  output logic [31:0]                        stall_cnt_o
`endif
);

  localparam int CNT_W = pipe_buf_cnt_w(DEPTH);
  localparam int PTR_W = pipe_buf_ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic full;
  logic empty;
  logic in_ready;
  logic out_valid;
  logic enq;
  logic deq;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake: a beat moves on a side only in a cycle where that side's valid
  // and ready are both high at the rising edge; valid never depends on ready.
  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    out_valid = !empty;
    if (READY_PASS != 0) begin
      in_ready = !full || out_ready_i;
    end else begin
      in_ready = !full;
    end
    enq = in_valid_i && in_ready;
    deq = out_valid && out_ready_i;
  end

  always_comb begin
    out_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr_q == PTR_W'(i)) begin
        out_data_o = mem_q[i];
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Storage is left intact; only the bookkeeping is cleared.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_ptr_q == PTR_W'(i)) begin
            mem_d[i] = in_data_i;
          end
        end
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (deq) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign count_o     = count_q;

`ifdef PIPE_BUF_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  // An offered beat must stay offered until taken, unless a redirect flushes it.
  a_in_valid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (in_valid_i && !in_ready_o && !flush_i) |=> in_valid_i);

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    (count_q <= FULL_CNT));

  a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid && !out_ready_i && !flush_i) |=> $stable(out_data_o));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: DEPTH=2/RP=1, DEPTH=3/RP=1 and DEPTH=1/RP=0 instances.
// Build with +define+PIPE_BUF_PERF_EN to also check the stall counter.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_flush;
  logic [63:0] d2_in_data, d2_out_data;
  logic [1:0]  d2_count;
  logic        d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_flush;
  logic [63:0] d3_in_data, d3_out_data;
  logic [1:0]  d3_count;
  logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_flush;
  logic [63:0] d1_in_data, d1_out_data;
  logic [0:0]  d1_count;
`ifdef PIPE_BUF_PERF_EN
  logic [31:0] d2_stall, d3_stall, d1_stall;
`endif

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  pipe_stage_buf #(.DATA_W(64), .DEPTH(2), .READY_PASS(1)) u_d2 (
    .clk_i(clk), .rst_i(rst), .flush_i(d2_flush),
    .in_valid_i(d2_in_valid), .in_ready_o(d2_in_ready), .in_data_i(d2_in_data),
    .out_valid_o(d2_out_valid), .out_ready_i(d2_out_ready), .out_data_o(d2_out_data),
    .count_o(d2_count)
`ifdef PIPE_BUF_PERF_EN
    , .stall_cnt_o(d2_stall)
`endif
  );

  pipe_stage_buf #(.DATA_W(64), .DEPTH(3), .READY_PASS(1)) u_d3 (
    .clk_i(clk), .rst_i(rst), .flush_i(d3_flush),
    .in_valid_i(d3_in_valid), .in_ready_o(d3_in_ready), .in_data_i(d3_in_data),
    .out_valid_o(d3_out_valid), .out_ready_i(d3_out_ready), .out_data_o(d3_out_data),
    .count_o(d3_count)
`ifdef PIPE_BUF_PERF_EN
    , .stall_cnt_o(d3_stall)
`endif
  );

  pipe_stage_buf #(.DATA_W(64), .DEPTH(1), .READY_PASS(0)) u_d1 (
    .clk_i(clk), .rst_i(rst), .flush_i(d1_flush),
    .in_valid_i(d1_in_valid), .in_ready_o(d1_in_ready), .in_data_i(d1_in_data),
    .out_valid_o(d1_out_valid), .out_ready_i(d1_out_ready), .out_data_o(d1_out_data),
    .count_o(d1_count)
`ifdef PIPE_BUF_PERF_EN
    , .stall_cnt_o(d1_stall)
`endif
  );

  // Clock/reset helpers: tasks start 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers: apply inputs, let combinational paths settle, report handshakes.
  task automatic drive_d2(input logic v, input logic [63:0] d, input logic r, input logic fl,
                          output logic enq, output logic deq);
    d2_in_valid = v; d2_in_data = d; d2_out_ready = r; d2_flush = fl;
    #2;
    enq = d2_in_valid && d2_in_ready;
    deq = d2_out_valid && d2_out_ready;
  endtask

  task automatic drive_d3(input logic v, input logic [63:0] d, input logic r, input logic fl,
                          output logic enq, output logic deq);
    d3_in_valid = v; d3_in_data = d; d3_out_ready = r; d3_flush = fl;
    #2;
    enq = d3_in_valid && d3_in_ready;
    deq = d3_out_valid && d3_out_ready;
  endtask

  task automatic drive_d1(input logic v, input logic [63:0] d, input logic r, input logic fl,
                          output logic enq, output logic deq);
    d1_in_valid = v; d1_in_data = d; d1_out_ready = r; d1_flush = fl;
    #2;
    enq = d1_in_valid && d1_in_ready;
    deq = d1_out_valid && d1_out_ready;
  endtask

  task automatic test_reset();
    logic enq, deq;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (d2_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", d2_out_valid); end
    total++; if (d2_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", d2_in_ready); end
    total++; if (d2_count !== 2'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", d2_count); end
    total++; if (d2_out_data !== 64'h0) begin bad++; $display("FAIL rst_out_data: got %h want 0", d2_out_data); end
    total++; if (d1_in_ready !== 1'b1) begin bad++; $display("FAIL rst_d1_in_ready: got %b want 1", d1_in_ready); end
    rst = 1'b0;
    drive_d2(1'b1, 64'h5, 1'b0, 1'b0, enq, deq);
    tick();
    drive_d2(1'b0, 64'h0, 1'b0, 1'b0, enq, deq);
    total++; if (d2_count !== 2'd1) begin bad++; $display("FAIL pre_async_count: got %0d want 1", d2_count); end
    // Mid-cycle reset: outputs must clear with no clock edge.
    #2 rst = 1'b1;
    #1;
    total++; if (d2_out_valid !== 1'b0) begin bad++; $display("FAIL async_out_valid: got %b want 0", d2_out_valid); end
    total++; if (d2_count !== 2'd0) begin bad++; $display("FAIL async_count: got %0d want 0", d2_count); end
    total++; if (d2_in_ready !== 1'b1) begin bad++; $display("FAIL async_in_ready: got %b want 1", d2_in_ready); end
    total++; if (d2_out_data !== 64'h0) begin bad++; $display("FAIL async_out_data: got %h want 0", d2_out_data); end
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    logic enq, deq;
    logic [63:0] e;
    int first_deq = -1;
    int n_deq = 0;
    int model_cnt = 0;
    exp_q.delete();
    for (int c = 0; c < 12; c++) begin
      drive_d2(c < 8, 64'(c + 1), 1'b1, 1'b0, enq, deq);
      total++; if (d2_count !== 2'(model_cnt)) begin bad++; $display("FAIL stream_count c=%0d: got %0d want %0d", c, d2_count, model_cnt); end
      total++; if (enq !== (c < 8)) begin bad++; $display("FAIL stream_enq c=%0d: got %b want %b", c, enq, c < 8); end
      if (enq) exp_q.push_back(64'(c + 1));
      if (deq) begin
        if (first_deq < 0) first_deq = c;
        n_deq++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL stream_spurious: got %h want nothing", d2_out_data);
        end else begin
          e = exp_q.pop_front();
          if (d2_out_data !== e) begin bad++; $display("FAIL stream_data: got %h want %h", d2_out_data, e); end
        end
      end
      model_cnt = model_cnt + (enq ? 1 : 0) - (deq ? 1 : 0);
      tick();
    end
    total++; if (first_deq !== 1) begin bad++; $display("FAIL stream_latency: got %0d want 1", first_deq); end
    total++; if (n_deq !== 8) begin bad++; $display("FAIL stream_ndeq: got %0d want 8", n_deq); end
  endtask

  task automatic test_fill_pass();
    logic enq, deq;
    logic [63:0] e;
    exp_q.delete();
    drive_d2(1'b1, 64'hA, 1'b0, 1'b0, enq, deq);
    if (enq) exp_q.push_back(64'hA);
    tick();
    drive_d2(1'b1, 64'hB, 1'b0, 1'b0, enq, deq);
    if (enq) exp_q.push_back(64'hB);
    tick();
    drive_d2(1'b0, 64'h0, 1'b0, 1'b0, enq, deq);
    total++; if (d2_count !== 2'd2) begin bad++; $display("FAIL fill_count: got %0d want 2", d2_count); end
    total++; if (d2_in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready: got %b want 0", d2_in_ready); end
    total++; if (d2_out_data !== 64'hA) begin bad++; $display("FAIL fill_head: got %h want a", d2_out_data); end
    tick();
    drive_d2(1'b1, 64'hC, 1'b1, 1'b0, enq, deq);
    total++; if (d2_in_ready !== 1'b1) begin bad++; $display("FAIL pass_in_ready: got %b want 1", d2_in_ready); end
    if (enq) exp_q.push_back(64'hC);
    if (deq) begin
      e = exp_q.pop_front();
      total++; if (d2_out_data !== e) begin bad++; $display("FAIL pass_data: got %h want %h", d2_out_data, e); end
    end
    tick();
    drive_d2(1'b0, 64'h0, 1'b0, 1'b0, enq, deq);
    total++; if (d2_count !== 2'd2) begin bad++; $display("FAIL pass_count: got %0d want 2", d2_count); end
    total++; if (d2_out_data !== 64'hB) begin bad++; $display("FAIL pass_head: got %h want b", d2_out_data); end
    tick();
    for (int c = 0; c < 4; c++) begin
      drive_d2(1'b0, 64'h0, 1'b1, 1'b0, enq, deq);
      if (deq) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL drain_spurious: got %h want nothing", d2_out_data);
        end else begin
          e = exp_q.pop_front();
          if (d2_out_data !== e) begin bad++; $display("FAIL drain_data: got %h want %h", d2_out_data, e); end
        end
      end
      tick();
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drain_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    logic enq, deq;
    logic [63:0] e;
    exp_q.delete();
    drive_d2(1'b1, 64'h21, 1'b0, 1'b0, enq, deq);
    if (enq) exp_q.push_back(64'h21);
    tick();
    drive_d2(1'b1, 64'h22, 1'b0, 1'b0, enq, deq);
    if (enq) exp_q.push_back(64'h22);
    tick();
    drive_d2(1'b0, 64'h0, 1'b0, 1'b0, enq, deq);
    total++; if (d2_count !== 2'd2) begin bad++; $display("FAIL flush_pre_count: got %0d want 2", d2_count); end
    tick();
    // The dequeue in the flush cycle still counts; the enqueue is discarded.
    drive_d2(1'b1, 64'hFF, 1'b1, 1'b1, enq, deq);
    if (deq) begin
      e = exp_q.pop_front();
      total++; if (d2_out_data !== e) begin bad++; $display("FAIL flush_deq: got %h want %h", d2_out_data, e); end
    end
    exp_q.delete();
    tick();
    drive_d2(1'b0, 64'h0, 1'b1, 1'b0, enq, deq);
    total++; if (d2_count !== 2'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", d2_count); end
    total++; if (d2_out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", d2_out_valid); end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive_d2(1'b0, 64'h0, 1'b1, 1'b0, enq, deq);
      total++; if (d2_out_valid !== 1'b0) begin bad++; $display("FAIL flush_emit: got %h want nothing", d2_out_data); end
      tick();
    end
    drive_d2(1'b1, 64'h33, 1'b1, 1'b0, enq, deq);
    tick();
    drive_d2(1'b0, 64'h0, 1'b1, 1'b0, enq, deq);
    total++; if (deq !== 1'b1 || d2_out_data !== 64'h33) begin bad++; $display("FAIL post_flush: got valid=%b data=%h want 1/33", deq, d2_out_data); end
    tick();
  endtask

  task automatic test_wrap_d3();
    logic enq, deq, r, prev_stall;
    logic [63:0] e, prev_data;
    int idx = 0;
    int model_cnt = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    exp_q.delete();
    for (int c = 0; c < 300 && (idx < 10 || exp_q.size() != 0); c++) begin
      r = ($urandom_range(0, 2) == 0);
      drive_d3(idx < 10, 64'(16 + idx), r, 1'b0, enq, deq);
      total++; if (d3_count !== 2'(model_cnt) || d3_count > 2'd3) begin bad++; $display("FAIL wrap_count c=%0d: got %0d want %0d", c, d3_count, model_cnt); end
      if (prev_stall) begin
        total++; if (d3_out_data !== prev_data) begin bad++; $display("FAIL wrap_hold: got %h want %h", d3_out_data, prev_data); end
      end
      if (enq) exp_q.push_back(64'(16 + idx));
      if (deq) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL wrap_spurious: got %h want nothing", d3_out_data);
        end else begin
          e = exp_q.pop_front();
          if (d3_out_data !== e) begin bad++; $display("FAIL wrap_data: got %h want %h", d3_out_data, e); end
        end
      end
      prev_stall = d3_out_valid && !r;
      prev_data = d3_out_data;
      if (enq) idx++;
      model_cnt = model_cnt + (enq ? 1 : 0) - (deq ? 1 : 0);
      tick();
    end
    total++; if (idx != 10 || exp_q.size() != 0) begin bad++; $display("FAIL wrap_timeout: got sent=%0d left=%0d want 10/0", idx, exp_q.size()); end
  endtask

  task automatic test_depth1();
    logic enq, deq;
    logic [63:0] e;
    int idx = 0;
    exp_q.delete();
    drive_d1(1'b1, 64'h3F, 1'b0, 1'b0, enq, deq);
    if (enq) exp_q.push_back(64'h3F);
    tick();
    for (int s = 0; s < 5; s++) begin
      drive_d1(1'b0, 64'h0, 1'b0, 1'b0, enq, deq);
      tick();
    end
    // Full DEPTH=1 without ready pass-through: one transfer every other cycle.
    for (int c = 0; c < 10; c++) begin
      drive_d1(idx < 4, 64'(64 + idx), 1'b1, 1'b0, enq, deq);
      if (c == 0) begin
        total++; if (d1_in_ready !== 1'b0) begin bad++; $display("FAIL d1_in_ready: got %b want 0", d1_in_ready); end
`ifdef PIPE_BUF_PERF_EN
        total++; if (d1_stall !== 32'd5) begin bad++; $display("FAIL d1_stall: got %0d want 5", d1_stall); end
`endif
      end
      total++; if (enq !== (c % 2 == 1 && c <= 7)) begin bad++; $display("FAIL d1_enq c=%0d: got %b", c, enq); end
      total++; if (deq !== (c % 2 == 0 && c <= 8)) begin bad++; $display("FAIL d1_deq c=%0d: got %b", c, deq); end
      if (enq) exp_q.push_back(64'(64 + idx));
      if (deq) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL d1_spurious: got %h want nothing", d1_out_data);
        end else begin
          e = exp_q.pop_front();
          if (d1_out_data !== e) begin bad++; $display("FAIL d1_data: got %h want %h", d1_out_data, e); end
        end
      end
      if (enq) idx++;
      tick();
    end
    drive_d1(1'b0, 64'h0, 1'b0, 1'b1, enq, deq);
    tick();
    drive_d1(1'b0, 64'h0, 1'b0, 1'b0, enq, deq);
    total++; if (d1_count !== 1'b0) begin bad++; $display("FAIL d1_end_count: got %0d want 0", d1_count); end
`ifdef PIPE_BUF_PERF_EN
    total++; if (d1_stall !== 32'd5) begin bad++; $display("FAIL d1_stall_flush: got %0d want 5", d1_stall); end
`endif
    tick();
  endtask

  initial begin
    rst = 1'b1;
    d2_in_valid = 1'b0; d2_in_data = '0; d2_out_ready = 1'b0; d2_flush = 1'b0;
    d3_in_valid = 1'b0; d3_in_data = '0; d3_out_ready = 1'b0; d3_flush = 1'b0;
    d1_in_valid = 1'b0; d1_in_data = '0; d1_out_ready = 1'b0; d1_flush = 1'b0;
    test_reset();
    test_streaming();
    test_fill_pass();
    test_flush();
    test_wrap_d3();
    test_depth1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
